// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out handshake bundle for conv_window_gen.
// slave = the window generator, master = the pixel source plus window consumer.
interface conv_window_gen_if #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28
);
   localparam int RW = $clog2(IMG_H);
   localparam int CW = $clog2(IMG_W);

   logic signed [DATA_W-1:0]     in_pixel;
   logic                         in_valid;
   logic                         in_ready;
   logic [4:0][4:0][DATA_W-1:0]  window;
   logic                         out_valid;
   logic                         out_ready;
   logic [RW-1:0]                out_row;
   logic [CW-1:0]                out_col;
   logic                         out_last;

   modport slave (
      input  in_pixel, in_valid, out_ready,
      output in_ready, window, out_valid, out_row, out_col, out_last
   );

   modport master (
      output in_pixel, in_valid, out_ready,
      input  in_ready, window, out_valid, out_row, out_col, out_last
   );
endinterface

// File: rtl/conv_window_gen.sv
// Streaming 5x5 window generator: four line buffers plus a 5x5 shift window,
// emitting every fully-interior window of a raster-order frame with position tags.
module conv_window_gen #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28
) (
   input  logic              clk,
   input  logic              rst,
   conv_window_gen_if.slave  bus
);
   localparam int RW = $clog2(IMG_H);
   localparam int CW = $clog2(IMG_W);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

   typedef logic signed [DATA_W-1:0] pix_t;

   // Row 0 holds the oldest buffered line, row 3 the newest.
   pix_t                        lbuf_q [4][IMG_W];
   logic [4:0][4:0][DATA_W-1:0] win_q, win_d;
   logic [RW-1:0]               r_q, r_d, row_q, row_d;
   logic [CW-1:0]               c_q, c_d, col_q, col_d;
   logic                        vld_q, vld_d, last_q, last_d;
   logic                        accept, emit;

   assign bus.in_ready  = !vld_q || bus.out_ready;
   assign accept        = bus.in_valid && bus.in_ready;
   assign emit          = accept && (r_q >= RW'(4)) && (c_q >= CW'(4));

   assign bus.window    = win_q;
   assign bus.out_valid = vld_q;
   assign bus.out_row   = row_q;
   assign bus.out_col   = col_q;
   assign bus.out_last  = last_q;

   always_comb begin
      r_d    = r_q;
      c_d    = c_q;
      win_d  = win_q;
      row_d  = row_q;
      col_d  = col_q;
      last_d = last_q;
      vld_d  = vld_q && !bus.out_ready;

      if (accept) begin
         if (c_q == COL_LAST) begin
            c_d = '0;
            r_d = (r_q == ROW_LAST) ? '0 : r_q + 1'b1;
         end else begin
            c_d = c_q + 1'b1;
         end

         for (int i = 0; i < 5; i++)
            for (int j = 0; j < 4; j++)
               win_d[i][j] = win_q[i][j+1];
         for (int i = 0; i < 4; i++)
            win_d[i][4] = lbuf_q[i][c_q];
         win_d[4][4] = bus.in_pixel;
      end

      // Tags are only loaded on an emitting accept so they stay frozen under backpressure.
      if (emit) begin
         vld_d  = 1'b1;
         row_d  = r_q - RW'(4);
         col_d  = c_q - CW'(4);
         last_d = (r_q == ROW_LAST) && (c_q == COL_LAST);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q    <= '0;
         c_q    <= '0;
         win_q  <= '0;
         row_q  <= '0;
         col_q  <= '0;
         last_q <= 1'b0;
         vld_q  <= 1'b0;
      end else begin
         r_q    <= r_d;
         c_q    <= c_d;
         win_q  <= win_d;
         row_q  <= row_d;
         col_q  <= col_d;
         last_q <= last_d;
         vld_q  <= vld_d;
      end
   end

   // Line buffer contents never need clearing: rows 0..3 of a frame are never emitted.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < 3; i++)
            lbuf_q[i][c_q] <= lbuf_q[i+1][c_q];
         lbuf_q[3][c_q] <= bus.in_pixel;
      end
   end
endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen on an 8x6 frame: an image-array model predicts every
// window from the accepted pixels, plus literal checks on selected windows.
module tb_conv_window_gen;
   localparam int W = 8;
   localparam int H = 6;

   typedef struct packed {
      logic [4:0][4:0][7:0] win;
      logic [2:0]           row;
      logic [2:0]           col;
      logic                 last;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   conv_window_gen_if #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) bus ();
   conv_window_gen #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   n_vec = 0;
   int   n_err = 0;
   ent_t log_q[$];
   ent_t basic_q[$];

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Behavioural model: the frame as a 2-D image, windows read straight out of it.
   logic [7:0]           img [H][W];
   int                   m_r = 0, m_c = 0;
   logic                 exp_valid = 1'b0;
   ent_t                 exp_e = '0;
   logic                 prev_hold = 1'b0;
   logic [4:0][4:0][7:0] prev_win = '0;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
         chk("rst_window", 256'(bus.window), 256'(0));
         m_r = 0; m_c = 0; exp_valid = 1'b0; exp_e = '0; prev_hold = 1'b0;
      end else begin
         chk("in_ready", 256'(bus.in_ready), 256'(!bus.out_valid || bus.out_ready));
         chk("out_valid", 256'(bus.out_valid), 256'(exp_valid));
         if (exp_valid)
            chk("window_tags", 256'({bus.window, bus.out_row, bus.out_col, bus.out_last}), 256'(exp_e));
         if (prev_hold)
            chk("hold_window", 256'(bus.window), 256'(prev_win));
         prev_hold = bus.out_valid && !bus.out_ready;
         prev_win  = bus.window;
         if (bus.out_valid && bus.out_ready)
            log_q.push_back(ent_t'({bus.window, bus.out_row, bus.out_col, bus.out_last}));

         // Predict the effect of the coming rising edge.
         if (bus.in_valid && bus.in_ready) begin
            img[m_r][m_c] = bus.in_pixel;
            if (m_r >= 4 && m_c >= 4) begin
               for (int i = 0; i < 5; i++)
                  for (int j = 0; j < 5; j++)
                     exp_e.win[i][j] = img[m_r-4+i][m_c-4+j];
               exp_e.row  = 3'(m_r - 4);
               exp_e.col  = 3'(m_c - 4);
               exp_e.last = (m_r == H-1) && (m_c == W-1);
               exp_valid  = 1'b1;
            end else if (bus.out_ready) begin
               exp_valid = 1'b0;
            end
            m_c = m_c + 1;
            if (m_c == W) begin
               m_c = 0;
               m_r = (m_r == H-1) ? 0 : m_r + 1;
            end
         end else if (bus.out_ready) begin
            exp_valid = 1'b0;
         end
      end
   end

   function automatic logic [7:0] pix_of(input int mode, input int r, input int c);
      case (mode)
         0:       return 8'(r*8 + c);
         1:       return 8'(40 - (r*8 + c));
         2:       return (r == 4 && c == 4) ? 8'h7f : 8'h80;
         default: return 8'($urandom);
      endcase
   endfunction

   // Drives n accepted pixels starting at (0,0); bp: 0 ready, 1 stall first window 3 cycles, 2 random.
   task automatic run_pixels(input int mode, input int n, input bit bubble, input int bp);
      int   k = 0, cyc = 0, stalls = 0;
      logic acc;
      while (k < n && cyc < 4000) begin
         bus.in_valid = bubble ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.in_pixel = pix_of(mode, (k / W) % H, k % W);
         if (bp == 1) begin
            bus.out_ready = !(bus.out_valid && stalls < 3);
            if (!bus.out_ready) stalls++;
         end else if (bp == 2) begin
            bus.out_ready = 1'($urandom_range(0, 1));
         end else begin
            bus.out_ready = 1'b1;
         end
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
         @(posedge clk);
         #1;
         if (acc) k++;
         cyc++;
      end
      chk("pixels_accepted", 256'(k), 256'(n));
   endtask

   task automatic drain();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_out_valid", 256'(bus.out_valid), 256'(0));
      chk("async_rst_in_ready", 256'(bus.in_ready), 256'(1));
      chk("async_rst_tags", 256'({bus.window, bus.out_row, bus.out_col, bus.out_last}), 256'(0));
      @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic cmp_basic(input string nm, input int b);
      chk({nm, "_count"}, 256'(log_q.size() - b), 256'(8));
      if (log_q.size() >= b + 8 && basic_q.size() == 8)
         for (int i = 0; i < 8; i++)
            chk({nm, "_seq"}, 256'(log_q[b+i]), 256'(basic_q[i]));
   endtask

   initial begin
      int   b;
      ent_t e;
      bus.in_valid  = 1'b0;
      bus.in_pixel  = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", 256'({bus.out_valid, bus.in_ready, bus.window, bus.out_row, bus.out_col, bus.out_last}),
          {1'b0, 1'b1, 254'(0)} >> 0 == 0 ? 256'(0) : 256'({1'b0, 1'b1, 207'(0)}));
      rst = 1'b0;

      // Basic frame
      b = log_q.size();
      run_pixels(0, W*H, 1'b0, 0);
      drain();
      chk("basic_count", 256'(log_q.size() - b), 256'(8));
      e = '0;
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++)
            e.win[i][j] = 8'(i*8 + j);
      if (log_q.size() >= b + 8) begin
         chk("basic_first", 256'(log_q[b]), 256'(e));
         chk("basic_8th_w00", 256'(log_q[b+7].win[0][0]), 256'(11));
         chk("basic_8th_tags", 256'({log_q[b+7].row, log_q[b+7].col, log_q[b+7].last}), 256'({3'd1, 3'd3, 1'b1}));
         for (int i = 0; i < 8; i++) basic_q.push_back(log_q[b+i]);
      end

      // Backpressure
      b = log_q.size();
      run_pixels(0, W*H, 1'b0, 1);
      drain();
      cmp_basic("bp", b);

      // Input bubbles
      b = log_q.size();
      run_pixels(0, W*H, 1'b1, 0);
      drain();
      cmp_basic("bubble", b);

      // Back-to-back frames
      b = log_q.size();
      run_pixels(0, W*H, 1'b0, 0);
      run_pixels(1, W*H, 1'b0, 0);
      drain();
      chk("b2b_count", 256'(log_q.size() - b), 256'(16));
      if (log_q.size() >= b + 9) begin
         chk("f2_first_w00", 256'(log_q[b+8].win[0][0]), 256'(40));
         chk("f2_first_w44", 256'(log_q[b+8].win[4][4]), 256'(4));
         chk("f2_first_tags", 256'({log_q[b+8].row, log_q[b+8].col}), 256'(0));
      end

      // Reset after 20 pixels, then a clean frame
      run_pixels(0, 20, 1'b0, 0);
      do_reset();
      b = log_q.size();
      run_pixels(0, W*H, 1'b0, 0);
      drain();
      cmp_basic("after_rst20", b);

      // Reset while a window is held under backpressure
      run_pixels(0, 37, 1'b0, 0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      chk("held_before_rst", 256'(bus.out_valid), 256'(1));
      do_reset();
      b = log_q.size();
      run_pixels(0, W*H, 1'b0, 0);
      drain();
      cmp_basic("after_rst37", b);

      // Sign preservation
      b = log_q.size();
      run_pixels(2, W*H, 1'b0, 0);
      drain();
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++)
            e.win[i][j] = (i == 4 && j == 4) ? 8'h7f : 8'h80;
      if (log_q.size() > b)
         chk("sign_first", 256'(log_q[b].win), 256'(e.win));
      else
         chk("sign_count", 256'(log_q.size() - b), 256'(8));

      // Random pixels, random bubbles, random backpressure, two frames
      b = log_q.size();
      run_pixels(3, 2*W*H, 1'b1, 2);
      drain();
      chk("random_count", 256'(log_q.size() - b), 256'(16));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
